// File: rtl/pico_run_ctrl.sv
// Run-control sequencer for the PicoRISC-V core: host byte commands,
// instruction memory loading, and run/step/halt/breakpoint gating.
module pico_run_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [7:0]         cmd_data,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_waddr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_en,
    output logic               core_rst,
    input  logic               core_done,
    input  logic [ADDR_W-1:0]  core_pc_next,
    output logic [7:0]         status
);

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2
    } state_t;

    localparam logic [2:0] OP_SET_ADDR = 3'd0;
    localparam logic [2:0] OP_LOAD     = 3'd1;
    localparam logic [2:0] OP_RUN      = 3'd2;
    localparam logic [2:0] OP_STEP     = 3'd3;
    localparam logic [2:0] OP_HALT     = 3'd4;
    localparam logic [2:0] OP_SET_BP   = 3'd5;
    localparam logic [2:0] OP_CLR_BP   = 3'd6;
    localparam logic [2:0] OP_CORE_RST = 3'd7;

    state_t              state, state_nx;
    logic                core_en_nx, core_rst_nx;
    logic                imem_we_nx;
    logic [ADDR_W-1:0]   waddr_nx;
    logic [INSTR_W-1:0]  wdata_nx;
    logic [ADDR_W-1:0]   wptr, wptr_nx;
    logic [7:0]          lo_byte, lo_byte_nx;
    logic                lo_pend, lo_pend_nx;
    logic                bp_en, bp_en_nx;
    logic [ADDR_W-1:0]   bp_addr, bp_addr_nx;
    logic                bp_hit, bp_hit_nx;
    logic                cmd_err, cmd_err_nx;
    logic                accept;
    logic                bp_match;

    assign cmd_ready = (state != STEP);
    assign accept    = cmd_valid && cmd_ready;
    // Match against the registered breakpoint, so a SET_BP landing
    // together with core_done still compares with the old address.
    assign bp_match  = core_done && bp_en && (core_pc_next == bp_addr);
    assign status    = {state, bp_en, bp_hit, lo_pend, cmd_err, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HALTED;
            core_en    <= 1'b0;
            core_rst   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            wptr       <= '0;
            lo_byte    <= '0;
            lo_pend    <= 1'b0;
            bp_en      <= 1'b0;
            bp_addr    <= '0;
            bp_hit     <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            core_en    <= core_en_nx;
            core_rst   <= core_rst_nx;
            imem_we    <= imem_we_nx;
            imem_waddr <= waddr_nx;
            imem_wdata <= wdata_nx;
            wptr       <= wptr_nx;
            lo_byte    <= lo_byte_nx;
            lo_pend    <= lo_pend_nx;
            bp_en      <= bp_en_nx;
            bp_addr    <= bp_addr_nx;
            bp_hit     <= bp_hit_nx;
            cmd_err    <= cmd_err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        core_en_nx  = core_en;
        core_rst_nx = 1'b0;
        imem_we_nx  = 1'b0;
        waddr_nx    = imem_waddr;
        wdata_nx    = imem_wdata;
        wptr_nx     = wptr;
        lo_byte_nx  = lo_byte;
        lo_pend_nx  = lo_pend;
        bp_en_nx    = bp_en;
        bp_addr_nx  = bp_addr;
        bp_hit_nx   = bp_hit;
        cmd_err_nx  = cmd_err;
        unique case (state)
            HALTED: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_SET_ADDR: begin
                            wptr_nx    = cmd_data;
                            lo_pend_nx = 1'b0;
                        end
                        OP_LOAD: begin
                            if (lo_pend) begin
                                imem_we_nx = 1'b1;
                                waddr_nx   = wptr;
                                wdata_nx   = {cmd_data, lo_byte};
                                wptr_nx    = wptr + ADDR_W'(1);
                                lo_pend_nx = 1'b0;
                            end else begin
                                lo_byte_nx = cmd_data;
                                lo_pend_nx = 1'b1;
                            end
                        end
                        OP_RUN: begin
                            state_nx   = RUN;
                            core_en_nx = 1'b1;
                            bp_hit_nx  = 1'b0;
                        end
                        OP_STEP: begin
                            state_nx   = STEP;
                            core_en_nx = 1'b1;
                            bp_hit_nx  = 1'b0;
                        end
                        OP_HALT: ;
                        OP_SET_BP: begin
                            bp_addr_nx = cmd_data;
                            bp_en_nx   = 1'b1;
                        end
                        OP_CLR_BP: bp_en_nx = 1'b0;
                        OP_CORE_RST: begin
                            core_rst_nx = 1'b1;
                            cmd_err_nx  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_HALT: begin
                            state_nx   = HALTED;
                            core_en_nx = 1'b0;
                        end
                        OP_SET_BP: begin
                            bp_addr_nx = cmd_data;
                            bp_en_nx   = 1'b1;
                        end
                        OP_CLR_BP: bp_en_nx = 1'b0;
                        default:   cmd_err_nx = 1'b1;
                    endcase
                end
                if (bp_match) begin
                    state_nx   = HALTED;
                    core_en_nx = 1'b0;
                    bp_hit_nx  = 1'b1;
                end
            end
            STEP: begin
                if (core_done) begin
                    state_nx   = HALTED;
                    core_en_nx = 1'b0;
                end
            end
            default: begin
                state_nx   = HALTED;
                core_en_nx = 1'b0;
            end
        endcase
    end

endmodule
